// File: rtl/signal_demux_1to4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : signal_demux_1to4                                             |
// | Purpose  : Sequential 1-to-4 stream demultiplexer. Each input word is    |
// |            steered by in_sel into one of four single-entry output slots, |
// |            each with its own valid/ready handshake, so a stalled channel |
// |            only blocks words addressed to it. Keeps a per-channel        |
// |            delivered-word counter for debug.                             |
// | Ports    : clk, rst            clock, synchronous active-high reset      |
// |            in_data/in_sel      input word and destination channel        |
// |            in_valid/in_ready   input handshake                           |
// |            in_bcast            broadcast request (macro builds only)     |
// |            out_data            channel k word at [k*WIDTH +: WIDTH]      |
// |            out_valid/out_ready per-channel output handshake              |
// |            clr_cnt             synchronous clear of all counters         |
// |            word_cnt            channel k count at [k*CNT_W +: CNT_W]     |
// | Options  : SPLITTER_BROADCAST_EN adds in_bcast; a broadcast word loads   |
// |            all four slots at once and needs all four to be free.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module signal_demux_1to4 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
`ifdef SPLITTER_BROADCAST_EN
  input  logic               in_bcast,
`endif
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  input  logic               clr_cnt,
  output logic [4*CNT_W-1:0] word_cnt
);

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q [4];
  slot_state_e      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];

  logic [3:0] free;       // slot can take a word this cycle
  logic [3:0] load;       // slot captures in_data at the next edge
  logic [3:0] drain;      // output handshake on the slot this cycle
  logic       bcast_req;

  // Acceptance: a FULL slot whose consumer is ready counts as free, which is
  // what lets a single-entry slot sustain one word per cycle.
  always_comb begin
    free      = '0;
    load      = '0;
    drain     = '0;
    bcast_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      free[k]  = (state_q[k] == SLOT_EMPTY) || out_ready[k];
      drain[k] = (state_q[k] == SLOT_FULL) && out_ready[k];
    end
`ifdef SPLITTER_BROADCAST_EN
    bcast_req = in_valid & in_bcast;
`endif
    if (rst) begin
      in_ready = 1'b0;
    end else if (bcast_req) begin
      in_ready = &free;
    end else begin
      in_ready = free[in_sel];
    end
    for (int k = 0; k < 4; k++) begin
      load[k] = in_valid & in_ready & (bcast_req | (in_sel == 2'(k)));
    end
  end

  // Next state per slot. A load wins over a drain so drain-and-refill in the
  // same cycle leaves the slot FULL with the new word.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      cnt_d[k]   = cnt_q[k];
      if (load[k]) begin
        state_d[k] = SLOT_FULL;
        data_d[k]  = in_data;
      end else if (drain[k]) begin
        state_d[k] = SLOT_EMPTY;
      end
      // Clear takes priority over a coincident handshake.
      if (clr_cnt) begin
        cnt_d[k] = '0;
      end else if (drain[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= SLOT_EMPTY;
        data_q[k]  <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_out
    assign out_data[k*WIDTH +: WIDTH] = data_q[k];
    assign out_valid[k]               = (state_q[k] == SLOT_FULL);
    assign word_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_signal_demux_1to4.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_signal_demux_1to4                                          |
// | Purpose  : Self-checking bench for signal_demux_1to4. A queue-per-channel|
// |            scoreboard tracks words accepted but not yet delivered, plus  |
// |            expected delivered counts; directed and random scenarios      |
// |            compare the DUT against it. Broadcast checks are built when   |
// |            SPLITTER_BROADCAST_EN is defined.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_signal_demux_1to4;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic               in_bcast;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic               clr_cnt;
  logic [4*CNT_W-1:0] word_cnt;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: words accepted per channel and not yet handed downstream.
  logic [WIDTH-1:0] pend [4][$];
  int unsigned      exp_cnt [4];

  always #5 clk = ~clk;

  signal_demux_1to4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef SPLITTER_BROADCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr_cnt   (clr_cnt),
    .word_cnt  (word_cnt)
  );

  function automatic logic is_bcast();
`ifdef SPLITTER_BROADCAST_EN
    return in_valid && in_bcast;
`else
    return 1'b0;
`endif
  endfunction

  // Whether the block may take a word now, from the scoreboard's view:
  // a channel with nothing outstanding, or one being drained this cycle.
  function automatic logic model_ready();
    logic all_free;
    if (rst) return 1'b0;
    if (is_bcast()) begin
      all_free = 1'b1;
      for (int k = 0; k < 4; k++)
        if (pend[k].size() != 0 && !out_ready[k]) all_free = 1'b0;
      return all_free;
    end
    return (pend[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (pend[k].size() != 0);
    return v;
  endfunction

  function automatic logic [4*CNT_W-1:0] model_cnt();
    logic [4*CNT_W-1:0] c;
    for (int k = 0; k < 4; k++) c[k*CNT_W +: CNT_W] = CNT_W'(exp_cnt[k]);
    return c;
  endfunction

  // Advance one clock and move the scoreboard along with the current inputs.
  task automatic tick();
    logic       rdy;
    logic       bc;
    logic [3:0] hs;
    rdy = model_ready();
    bc  = is_bcast();
    for (int k = 0; k < 4; k++) hs[k] = (pend[k].size() != 0) && out_ready[k];
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        pend[k].delete();
        exp_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (hs[k]) begin
          void'(pend[k].pop_front());
          exp_cnt[k] = (exp_cnt[k] + 1) % (1 << CNT_W);
        end
        if (clr_cnt) exp_cnt[k] = 0;
      end
      if (in_valid && rdy) begin
        for (int k = 0; k < 4; k++)
          if (bc || in_sel == 2'(k)) pend[k].push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    in_bcast  = 1'b0;
    clr_cnt   = 1'b0;
    out_ready = 4'b1111;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 4'b0000;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== '0 || word_cnt !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h cnt=%h expected all zero",
               out_valid, out_data, word_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single_word();
    apply_reset();
    in_valid = 1'b1; in_data = 8'hA1; in_sel = 2'd2;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100 || out_data[2*WIDTH +: WIDTH] !== 8'hA1) begin
      failures++;
      $display("FAIL single_word_out: valid=%b ch2=%h expected 0100/a1",
               out_valid, out_data[2*WIDTH +: WIDTH]);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0000 || word_cnt[2*CNT_W +: CNT_W] !== 16'd1) begin
      failures++;
      $display("FAIL single_word_drain: valid=%b cnt2=%0d expected 0000/1",
               out_valid, word_cnt[2*CNT_W +: CNT_W]);
    end
  endtask

  task automatic test_stall_and_independence();
    apply_reset();
    out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 8'h11; in_sel = 2'd1;
    tick();
    in_data = 8'h22;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_ready: got %b expected 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[WIDTH +: WIDTH] !== 8'h11) begin
      failures++;
      $display("FAIL stall_hold: valid1=%b ch1=%h expected 1/11",
               out_valid[1], out_data[WIDTH +: WIDTH]);
    end
    // Channel 1 is stalled and full; channel 3 must still accept at once.
    in_data = 8'h33; in_sel = 2'd3;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL indep_ready: got %b expected 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b1010 || out_data[3*WIDTH +: WIDTH] !== 8'h33) begin
      failures++;
      $display("FAIL indep_out: valid=%b ch3=%h expected 1010/33",
               out_valid, out_data[3*WIDTH +: WIDTH]);
    end
    // Release channel 1; the held 0x22 follows straight after 0x11.
    in_data = 8'h22; in_sel = 2'd1; out_ready = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0010 || out_data[WIDTH +: WIDTH] !== 8'h22) begin
      failures++;
      $display("FAIL release_out: valid=%b ch1=%h expected 0010/22",
               out_valid, out_data[WIDTH +: WIDTH]);
    end
    tick();
    checks++;
    if (word_cnt[CNT_W +: CNT_W] !== 16'd2 || word_cnt[3*CNT_W +: CNT_W] !== 16'd1) begin
      failures++;
      $display("FAIL release_counts: cnt1=%0d cnt3=%0d expected 2/1",
               word_cnt[CNT_W +: CNT_W], word_cnt[3*CNT_W +: CNT_W]);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    apply_reset();
    bad = 0;
    in_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      #1;
      if (in_ready !== 1'b1) bad++;
      tick();
      if (out_valid !== 4'b0001 || out_data[WIDTH-1:0] !== 8'h40 + 8'(i)) bad++;
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stream_order: %0d bad cycles expected 0", bad);
    end
    checks++;
    if (word_cnt[CNT_W-1:0] !== 16'd8 || out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL stream_count: cnt0=%0d valid=%b expected 8/0000",
               word_cnt[CNT_W-1:0], out_valid);
    end
  endtask

  task automatic test_interleave();
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i % 4);
      in_data  = 8'h90 + 8'(i);
      #1;
      if (in_ready !== 1'b1) bad++;
      tick();
      if (out_valid !== (4'b0001 << (i % 4)) ||
          out_data[(i % 4)*WIDTH +: WIDTH] !== 8'h90 + 8'(i)) bad++;
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (bad != 0 || word_cnt !== {16'd2, 16'd2, 16'd2, 16'd2}) begin
      failures++;
      $display("FAIL interleave: bad=%0d cnt=%h expected 0/0002000200020002",
               bad, word_cnt);
    end
  endtask

  task automatic test_counter_edges();
    apply_reset();
    in_sel = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (word_cnt[CNT_W-1:0] !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_preload: got %h expected ffff", word_cnt[CNT_W-1:0]);
    end
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (word_cnt[CNT_W-1:0] !== 16'h0000) begin
      failures++;
      $display("FAIL cnt_wrap: got %h expected 0000", word_cnt[CNT_W-1:0]);
    end
    in_valid = 1'b1; in_data = 8'h02;
    tick();
    in_data = 8'h03;
    tick();
    // Channel 0 handshakes on this edge while clr_cnt is high.
    in_valid = 1'b0; clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++;
    if (word_cnt !== '0 || out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL cnt_clear_with_handshake: cnt=%h valid=%b expected 0/0000",
               word_cnt, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = 8'hC0 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = 8'hD0 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0111 || word_cnt !== {16'd1, 16'd1, 16'd1, 16'd1}) begin
      failures++;
      $display("FAIL midstream_setup: valid=%b cnt=%h expected 0111/all ones",
               out_valid, word_cnt);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 4'b0000 || out_data !== '0 || word_cnt !== '0) begin
      failures++;
      $display("FAIL midstream_reset: valid=%b data=%h cnt=%h expected zero",
               out_valid, out_data, word_cnt);
    end
    rst = 1'b0;
    out_ready = 4'b1111;
  endtask

`ifdef SPLITTER_BROADCAST_EN
  task automatic test_broadcast();
    apply_reset();
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h5C; in_sel = 2'd1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bcast_ready: got %b expected 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b1111 || out_data !== {4{8'h5C}}) begin
      failures++;
      $display("FAIL bcast_out: valid=%b data=%h expected 1111/5c5c5c5c",
               out_valid, out_data);
    end
    out_ready = 4'b1110; in_data = 8'h6D;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bcast_blocked: got %b expected 0", in_ready);
    end
    in_valid = 1'b0; in_bcast = 1'b0;
    tick();
    out_ready = 4'b1111;
    tick();
    checks++;
    if (word_cnt !== {16'd1, 16'd1, 16'd1, 16'd1}) begin
      failures++;
      $display("FAIL bcast_counts: got %h expected 0001000100010001", word_cnt);
    end
  endtask
`endif

  task automatic test_random();
    int bad_ready, bad_valid, bad_data, bad_cnt;
    logic [3:0] ev;
    apply_reset();
    bad_ready = 0; bad_valid = 0; bad_data = 0; bad_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      clr_cnt   = ($urandom_range(0, 31) == 0);
`ifdef SPLITTER_BROADCAST_EN
      in_bcast  = ($urandom_range(0, 5) == 0);
`endif
      #1;
      if (in_ready !== model_ready()) bad_ready++;
      tick();
      ev = model_valid();
      if (out_valid !== ev) bad_valid++;
      for (int k = 0; k < 4; k++)
        if (ev[k] && out_data[k*WIDTH +: WIDTH] !== pend[k][0]) bad_data++;
      if (word_cnt !== model_cnt()) bad_cnt++;
    end
    idle_inputs();
    checks++;
    if (bad_ready != 0) begin
      failures++;
      $display("FAIL random_in_ready: %0d bad cycles expected 0", bad_ready);
    end
    checks++;
    if (bad_valid != 0) begin
      failures++;
      $display("FAIL random_out_valid: %0d bad cycles expected 0", bad_valid);
    end
    checks++;
    if (bad_data != 0) begin
      failures++;
      $display("FAIL random_out_data: %0d bad words expected 0", bad_data);
    end
    checks++;
    if (bad_cnt != 0) begin
      failures++;
      $display("FAIL random_word_cnt: %0d bad cycles expected 0", bad_cnt);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_word();
    test_stall_and_independence();
    test_back_to_back();
    test_interleave();
    test_counter_edges();
    test_reset_midstream();
`ifdef SPLITTER_BROADCAST_EN
    test_broadcast();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/signal_demux_1to4.md
# signal_demux_1to4

Sequential 1-to-4 stream demultiplexer. It steers each input word to one of four output channels selected by `in_sel`. Each channel has a one-entry output register with a valid/ready handshake, so a stalled channel blocks only the words addressed to it. The block sits on the fan-out side of the signal-splitter datapath and is the complement of the 4:1 channel selector. It also keeps a per-channel delivered-word count for debug.

## Interface
Parameters:
- `WIDTH`, default 8: data word width.
- `CNT_W`, default 16: width of each per-channel delivered-word counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  2  destination channel, 0..3; sampled with `in_data`.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts the input word this cycle.
- `in_bcast`  in  1  broadcast request. Present only with `SPLITTER_BROADCAST_EN`.
- `out_data`  out  4*WIDTH  channel k word at `[k*WIDTH +: WIDTH]`.
- `out_valid`  out  4  bit k: channel k holds a word.
- `out_ready`  in  4  bit k: downstream k consumes the word this cycle.
- `clr_cnt`  in  1  synchronous clear of all counters.
- `word_cnt`  out  4*CNT_W  channel k delivered-word count at `[k*CNT_W +: CNT_W]`.

## Operation
- Each channel slot k is a two-state machine, EMPTY or FULL, with `out_valid[k]` = FULL.
- Slot k is free when EMPTY, or when FULL and `out_ready[k]`=1 (drain and refill in the same cycle).
- `in_ready` = free[in_sel]. It is combinational from `out_ready` and `in_sel`. It is forced to 0 while `rst`=1.
- An input transfer happens when `in_valid`=1 and `in_ready`=1. On a transfer, `out_data[in_sel]` <= `in_data` and slot `in_sel` goes to FULL.
- A FULL slot with `out_ready[k]`=1 and no new transfer goes to EMPTY.
- A FULL slot with `out_ready[k]`=0 holds `out_data[k]` stable. No overwrite, no drop.
- Channels are independent. Slots other than `in_sel` drain on their own `out_ready`.
- Counters:
  - `word_cnt[k]` increments by 1 on each output handshake (`out_valid[k]` and `out_ready[k]`).
  - It wraps from 2^CNT_W-1 to 0.
  - `clr_cnt`=1 forces all counters to 0, including in a cycle with a handshake.
- Reset behaviour:
  - `out_valid`=0, `out_data`=0, `word_cnt`=0, all slots EMPTY.
  - Reset mid-stream discards held words without any handshake.
  - `in_ready`=1 on the first cycle after `rst` deasserts.
- `in_sel` and `in_data` are don't-care when `in_valid`=0.

## Timing
- Latency is 1 cycle. A word accepted at edge N shows on `out_valid`/`out_data` after edge N.
- Throughput is 1 word/cycle per channel when downstream is always ready, including back-to-back words to the same channel.
- No combinational path from `in_data` to `out_data`. The only combinational paths are `out_ready`/`in_sel`/`rst` to `in_ready`.
- Interleaved selects (0,1,2,3,0,...) with all channels ready also sustain 1 word/cycle.

## Configuration
- `SPLITTER_BROADCAST_EN` defined:
  - Adds the `in_bcast` port.
  - When `in_valid`=1 and `in_bcast`=1, `in_ready` = AND of free[0..3], and `in_sel` is ignored.
  - A transfer loads `in_data` into all four slots in the same edge.
  - Each channel is then drained and counted independently.
- Not defined:
  - No `in_bcast` port.
  - Routing is unicast by `in_sel` only, with identical behaviour otherwise.

## Test plan
- Reset, then send 0xA1 with sel=2 and `out_ready`=4'b1111. Required: one cycle later `out_valid`=4'b0100, channel 2 data 0xA1; next cycle `out_valid`=0; `word_cnt[2]`=1.
- Stall: hold `out_ready[1]`=0, send 0x11 then 0x22 both with sel=1. Required: `in_ready`=0 on the second word, channel 1 holds 0x11. Release `out_ready[1]` and 0x22 follows the next cycle; nothing is lost.
- Independence: channel 1 stalled and full, send 0x33 with sel=3. Required: accepted immediately, `out_valid`=4'b1010.
- Streaming: 8 words with sel=0 back-to-back, always ready. Required: 8 consecutive valid cycles in order, `word_cnt[0]`=8.
- Counter edge cases: preload `word_cnt[0]` to 0xFFFF by handshakes (CNT_W=16), one more handshake gives 0. Assert `clr_cnt` together with a handshake and the result is 0. Assert `rst` while channels are full and all outputs go to 0 the next cycle.
- Broadcast (macro on): all channels free, send 0x5C with `in_bcast`=1. Required: `out_valid`=4'b1111, all data 0x5C. With `out_ready[0]`=0 held, a second broadcast sees `in_ready`=0.
